// File: rtl/debounce_inputs.sv
// debounce_inputs
//   Cleans the synchronized KEY0/SW0/SW1 levels with one saturating-counter
//   FSM per channel and produces registered clean levels plus one-cycle edge
//   pulses for the LED controller. KEY0 is active-low on the board and is
//   presented here as active-high keyDown.
//
// Ports
//   clock       system clock, rising edge
//   reset_L     asynchronous active-low reset
//   syncedKEY0  synchronized KEY0 (0 = pressed)
//   syncedSW0   synchronized SW0
//   syncedSW1   synchronized SW1
//   keyDown     debounced KEY0, 1 = held
//   keyPress    1-cycle pulse when keyDown rises
//   keyRelease  1-cycle pulse when keyDown falls
//   cleanSW0    debounced SW0
//   cleanSW1    debounced SW1
//   swChange    1-cycle pulse when either clean switch changes (one pulse if both)

// debounceChannel
//   One channel: STABLE_LO / WAIT_HI / STABLE_HI / WAIT_LO. A new level is
//   accepted after DEBOUNCE_CYCLES consecutive identical samples; any bounce
//   during WAIT drops straight back to the old stable state.
//
// Ports
//   clock, reset_L  as above
//   sample          raw synchronized level
//   level           registered clean level
//   acceptRise      combinational: level goes 0->1 at this edge
//   acceptFall      combinational: level goes 1->0 at this edge
module debounceChannel #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
  parameter bit RST_HI          = 1'b0
) (
  input  logic clock,
  input  logic reset_L,
  input  logic sample,
  output logic level,
  output logic acceptRise,
  output logic acceptFall
);

  typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} chState_t;

  localparam chState_t   RST_ST = RST_HI ? STABLE_HI : STABLE_LO;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  chState_t         state, stateNxt;
  logic [CNT_W-1:0] cnt, cntNxt;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state <= RST_ST;
      cnt   <= '0;
      level <= RST_HI;
    end else begin
      state <= stateNxt;
      cnt   <= cntNxt;
      if (acceptRise)      level <= 1'b1;
      else if (acceptFall) level <= 1'b0;
    end
  end

  always_comb begin
    stateNxt   = state;
    cntNxt     = cnt;
    acceptRise = 1'b0;
    acceptFall = 1'b0;
    case (state)
      STABLE_LO: begin
        if (sample) begin
          stateNxt = WAIT_HI;
          cntNxt   = CNT_W'(1);
        end else begin
          cntNxt   = '0;
        end
      end
      WAIT_HI: begin
        if (!sample) begin
          stateNxt = STABLE_LO;
          cntNxt   = '0;
        end else if (cnt == LAST) begin
          stateNxt   = STABLE_HI;
          cntNxt     = '0;
          acceptRise = 1'b1;
        end else begin
          cntNxt   = cnt + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        if (!sample) begin
          stateNxt = WAIT_LO;
          cntNxt   = CNT_W'(1);
        end else begin
          cntNxt   = '0;
        end
      end
      WAIT_LO: begin
        if (sample) begin
          stateNxt = STABLE_HI;
          cntNxt   = '0;
        end else if (cnt == LAST) begin
          stateNxt   = STABLE_LO;
          cntNxt     = '0;
          acceptFall = 1'b1;
        end else begin
          cntNxt   = cnt + CNT_W'(1);
        end
      end
      default: begin
        stateNxt = RST_ST;
        cntNxt   = '0;
      end
    endcase
  end

endmodule

module debounce_inputs #(
  parameter  int DEBOUNCE_CYCLES = 500_000,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clock,
  input  logic reset_L,
  input  logic syncedKEY0,
  input  logic syncedSW0,
  input  logic syncedSW1,
  output logic keyDown,
  output logic keyPress,
  output logic keyRelease,
  output logic cleanSW0,
  output logic cleanSW1,
  output logic swChange
);

  localparam int NUM_CH = 3;  // 0 = KEY0 (raw polarity), 1 = SW0, 2 = SW1

  logic [NUM_CH-1:0] raw, level, rise, fall;

  assign raw = {syncedSW1, syncedSW0, syncedKEY0};

  // KEY channel resets to raw-high (released); switches reset low.
  for (genvar i = 0; i < NUM_CH; i++) begin : gCh
    debounceChannel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .RST_HI         (i == 0)
    ) uCh (
      .clock     (clock),
      .reset_L   (reset_L),
      .sample    (raw[i]),
      .level     (level[i]),
      .acceptRise(rise[i]),
      .acceptFall(fall[i])
    );
  end

  // Raw KEY0 is active-low, so a falling clean raw level is a press.
  assign keyDown  = ~level[0];
  assign cleanSW0 = level[1];
  assign cleanSW1 = level[2];

  // Pulses register on the same edge the clean level changes.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      keyPress   <= 1'b0;
      keyRelease <= 1'b0;
      swChange   <= 1'b0;
    end else begin
      keyPress   <= fall[0];
      keyRelease <= rise[0];
      swChange   <= |{rise[2:1], fall[2:1]};
    end
  end

endmodule
